alt_mem_ddrx_burst_consume_sched: RTL and testbench
===================================================

// Module: alt_mem_ddrx_burst_consume_sched
// PURPOSE
//  Schedules write-data consumption against the burst tracking counter.
//  - Queues write commands with their size (in local bursts).
//  - Releases each command's consume pulse only once enough data bursts are pending.
//  - Drives the tracker's burst_consumed_valid/burstcount inputs.
//  - Sits between the command issue path and the write data ID manager.
// PARAMETERS
//  CFG_BURSTCOUNT_TRACKING_WIDTH  7  width of pending-burst count from tracker
//  CFG_INT_SIZE_WIDTH             4  width of per-command burst size
//  CFG_CMD_FIFO_DEPTH             8  command queue depth; power of 2, >=2
//  CFG_STALL_TIMEOUT              256  WAIT_DATA cycles before stall flag (feature only)
// PORTS
//  ctl_clk                        in   1    controller clock
//  ctl_reset                      in   1    synchronous, active-high reset
//  cmd_valid                      in   1    write command offered
//  cmd_ready                      out  1    command accepted when cmd_valid&cmd_ready
//  cmd_size                       in   INT_SIZE  bursts the command consumes
//  burst_pending_burstcount       in   TRACK  current pending count from tracker
//  burst_consumed_valid           out  1    consume pulse to tracker
//  burst_counsumed_burstcount     out  INT_SIZE  bursts consumed this pulse
//  sched_busy                     out  1    queue non-empty or consume in flight
//  err_zero_size                  out  1    1-cycle pulse: size-0 entry discarded
//  stall_err                      out  1    sticky stall flag (feature only, else 0)
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready, which is 1 in the first cycle after reset.
//    Reset also clears queue pointers/count, FSM=IDLE, timeout count.
//    Reset asserted mid-operation discards queued commands; no consume pulse
//    is issued in the cycle after reset.
//  Queue: cmd_ready = ~full.
//    Push while full is not accepted, even if a pop occurs that cycle.
//    A pushed entry is eligible from the next cycle; no same-cycle bypass.
//    Simultaneous push and pop leaves the count unchanged.
//  Availability:
//    avail = pending - (burst_consumed_valid ? burst_counsumed_burstcount : 0)
//    Compensates for the tracker's 1-cycle register; allows back-to-back consumes.
//    Compare is unsigned; size is zero-extended to TRACK width.
//  FSM (state registered; consume outputs registered):
//    IDLE: queue empty; go to WAIT_DATA on a non-empty queue.
//    WAIT_DATA: evaluates the head entry each cycle.
//      avail >= head size (size != 0): next cycle burst_consumed_valid=1,
//        burstcount = head size; pop.
//      Stays in WAIT_DATA if the queue is still non-empty, else goes to IDLE.
//      head size == 0: pop, pulse err_zero_size next cycle, no consume.
//  Latency: command accepted at cycle t, data already pending -> consume at t+2.
//  Max throughput: one consume per cycle.
//  Outputs never exceed pending; counter underflow is impossible by construction.
// CONFIGURATION
//  ALT_MEM_DDRX_BURST_SCHED_STALL_TIMEOUT_EN
//    Defined: a counter increments each cycle in WAIT_DATA without a pop and
//      clears on pop or IDLE.
//      At CFG_STALL_TIMEOUT it sets stall_err, which stays set until ctl_reset.
//    Undefined: no counter; stall_err tied to 0.
// STRUCTURE
//  Package alt_mem_ddrx_burst_sched_pkg holds:
//    FSM state encodings (IDLE, WAIT_DATA)
//    clog2 helper for FIFO pointer widths
//  Sub-module alt_mem_ddrx_sched_fifo holds the command queue:
//    sync FIFO, width INT_SIZE, depth CFG_CMD_FIFO_DEPTH
//    exposes full/empty and a head-of-queue read
//  Top holds the FSM, avail computation, output registers and timeout.
// TESTING
//  1 Pending=0, push size 4, then ramp pending 0..4:
//    consume pulse (4) exactly 1 cycle after pending reaches 4; none earlier.
//  2 Pending=10, push sizes 3,3,3 back-to-back:
//    three consecutive consume pulses; no double-count; 4th push size 2 waits.
//  3 Fill queue (8 pushes, pending=0):
//    cmd_ready=0 after 8th; 9th held.
//    Pending=1 plus size 1 head: pop, ready=1 next cycle.
//  4 Push size 0 between sizes 2 and 2, pending=4:
//    err_zero_size pulses once; consumes 2,2; no consume of 0.
//  5 Reset asserted with 3 queued commands: next cycle outputs 0,
//    queue empty, cmd_ready=1; no stray consume.
//  6 Feature on, CFG_STALL_TIMEOUT=16, size 5 head, pending=2:
//    stall_err rises after 16 cycles and stays set once data arrives.
//    Feature off: stall_err stays 0.

Source files
------------

// File: rtl/alt_mem_ddrx_burst_sched_pkg.sv
// Package for the burst consume scheduler.
//   - FSM state encodings (IDLE, WAIT_DATA) as plain logic constants so the
//     state register stays a simple vector in netlists and waveforms.
//   - clog2 helper used to size FIFO pointers and counters.
// Optional feature macro used elsewhere in this slice:
//   ALT_MEM_DDRX_BURST_SCHED_STALL_TIMEOUT_EN
package alt_mem_ddrx_burst_sched_pkg;

    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_WAIT_DATA = 1'b1;

    // Ceiling log2, with a minimum result of 1 so it can size a vector.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/alt_mem_ddrx_burst_consume_sched_if.sv
// Bus between the write command issue path / burst tracker and the burst
// consume scheduler.
//   cmd_valid/cmd_ready/cmd_size      : write command handshake
//   burst_pending_burstcount          : pending data bursts from the tracker
//   burst_consumed_valid/_burstcount  : consume pulse back to the tracker
//   sched_busy, err_zero_size, stall_err : status
// Modports:
//   slave  - the scheduler
//   master - whoever issues commands and models the tracker
interface alt_mem_ddrx_burst_consume_sched_if #(
    parameter int TRACK_W = 7,
    parameter int SIZE_W  = 4
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [SIZE_W-1:0]  cmd_size;
    logic [TRACK_W-1:0] burst_pending_burstcount;
    logic               burst_consumed_valid;
    logic [SIZE_W-1:0]  burst_counsumed_burstcount;
    logic               sched_busy;
    logic               err_zero_size;
    logic               stall_err;

    modport slave (
        input  cmd_valid,
        input  cmd_size,
        input  burst_pending_burstcount,
        output cmd_ready,
        output burst_consumed_valid,
        output burst_counsumed_burstcount,
        output sched_busy,
        output err_zero_size,
        output stall_err
    );

    modport master (
        output cmd_valid,
        output cmd_size,
        output burst_pending_burstcount,
        input  cmd_ready,
        input  burst_consumed_valid,
        input  burst_counsumed_burstcount,
        input  sched_busy,
        input  err_zero_size,
        input  stall_err
    );
endinterface

// File: rtl/alt_mem_ddrx_sched_fifo.sv
// Synchronous command FIFO holding per-command burst sizes.
// Ports:
//   clk, srst      : clock, synchronous active-high reset
//   push, push_data: write request (ignored while full, even if popping)
//   pop            : remove head entry (ignored while empty)
//   full, empty    : occupancy flags
//   count          : current number of entries
//   head_data      : head-of-queue entry, valid whenever !empty
module alt_mem_ddrx_sched_fifo
    import alt_mem_ddrx_burst_sched_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic                      full,
    output logic                      empty,
    output logic [clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]          head_data
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    // Full is judged on the registered count, so a pop in the same cycle
    // never makes room for a push.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // The head is read straight from the storage array so a newly pushed
    // entry can be evaluated in the very next cycle.
    assign head_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/alt_mem_ddrx_burst_consume_sched.sv
// Burst consume scheduler: queues write commands with their size in local
// bursts and releases one consume pulse per command once the burst tracker
// reports enough pending data bursts.
// Ports:
//   ctl_clk, ctl_reset : controller clock, synchronous active-high reset
//   bus (slave)        : command handshake, tracker pending count in,
//                        consume pulse out, busy / zero-size / stall status
// Optional feature, enabled by defining ALT_MEM_DDRX_BURST_SCHED_STALL_TIMEOUT_EN:
//   a stall counter that sets a sticky stall_err after CFG_STALL_TIMEOUT
//   WAIT_DATA cycles without a pop. When undefined, stall_err is 0 and the
//   CFG_STALL_TIMEOUT parameter does not exist.
module alt_mem_ddrx_burst_consume_sched
    import alt_mem_ddrx_burst_sched_pkg::*;
#(
    parameter int CFG_BURSTCOUNT_TRACKING_WIDTH = 7,
    parameter int CFG_INT_SIZE_WIDTH            = 4,
    parameter int CFG_CMD_FIFO_DEPTH            = 8
`ifdef ALT_MEM_DDRX_BURST_SCHED_STALL_TIMEOUT_EN
    ,
    parameter int CFG_STALL_TIMEOUT             = 256
`endif
) (
    input  logic                                ctl_clk,
    input  logic                                ctl_reset,
    alt_mem_ddrx_burst_consume_sched_if.slave   bus
);

    localparam int TRACK_W = CFG_BURSTCOUNT_TRACKING_WIDTH;
    localparam int SIZE_W  = CFG_INT_SIZE_WIDTH;
    localparam int CNT_W   = clog2(CFG_CMD_FIFO_DEPTH) + 1;

    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [SIZE_W-1:0]  fifo_head;

    logic [0:0]         state_reg;
    logic [0:0]         state_next;
    logic               consume_valid_reg;
    logic [SIZE_W-1:0]  consume_count_reg;
    logic               err_zero_reg;

    logic               push_ok;
    logic               eval;
    logic               pop;
    logic               head_zero;
    logic [TRACK_W-1:0] head_ext;
    logic [TRACK_W-1:0] consumed_amt;
    logic [TRACK_W:0]   avail_wide;
    logic [TRACK_W-1:0] avail;

    alt_mem_ddrx_sched_fifo #(
        .WIDTH (SIZE_W),
        .DEPTH (CFG_CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (ctl_clk),
        .srst      (ctl_reset),
        .push      (bus.cmd_valid),
        .push_data (bus.cmd_size),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_data (fifo_head)
    );

    assign push_ok = bus.cmd_valid & ~fifo_full;

    // The tracker only sees our consume pulse one cycle later, so the
    // pulse currently on the wire is subtracted here. Without this, two
    // back-to-back commands could both claim the same pending bursts.
    assign consumed_amt = consume_valid_reg ? TRACK_W'(consume_count_reg) : '0;
    assign avail_wide   = {1'b0, bus.burst_pending_burstcount} - {1'b0, consumed_amt};
    assign avail        = avail_wide[TRACK_W] ? '0 : avail_wide[TRACK_W-1:0];

    assign head_ext  = TRACK_W'(fifo_head);
    assign head_zero = (fifo_head == '0);

    // WAIT_DATA is entered in the same edge that writes the first entry,
    // so the head is evaluated the cycle after acceptance and the consume
    // pulse lands two cycles after the command was accepted.
    assign eval = (state_reg == ST_WAIT_DATA) && !fifo_empty;
    assign pop  = eval && (head_zero || (avail >= head_ext));

    // Next state tracks whether the queue will still hold entries after
    // this cycle's push and pop.
    always_comb begin
        state_next = ST_IDLE;
        if (push_ok
            || (fifo_count > CNT_W'(1))
            || ((fifo_count == CNT_W'(1)) && !pop)) begin
            state_next = ST_WAIT_DATA;
        end
    end

    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            state_reg         <= ST_IDLE;
            consume_valid_reg <= 1'b0;
            consume_count_reg <= '0;
            err_zero_reg      <= 1'b0;
        end else begin
            state_reg         <= state_next;
            consume_valid_reg <= pop && !head_zero;
            consume_count_reg <= (pop && !head_zero) ? fifo_head : '0;
            err_zero_reg      <= pop && head_zero;
        end
    end

`ifdef ALT_MEM_DDRX_BURST_SCHED_STALL_TIMEOUT_EN
    localparam int TO_W = clog2(CFG_STALL_TIMEOUT + 1);

    logic [TO_W-1:0] stall_cnt_reg;
    logic            stall_reg;

    // Counts consecutive WAIT_DATA cycles without a pop; saturates at the
    // timeout so it cannot wrap while the head stays starved.
    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            stall_cnt_reg <= '0;
            stall_reg     <= 1'b0;
        end else if ((state_reg == ST_WAIT_DATA) && !pop) begin
            if (stall_cnt_reg != TO_W'(CFG_STALL_TIMEOUT)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (stall_cnt_reg == TO_W'(CFG_STALL_TIMEOUT - 1)) begin
                stall_reg <= 1'b1;
            end
        end else begin
            stall_cnt_reg <= '0;
        end
    end

    assign bus.stall_err = stall_reg;
`else
    assign bus.stall_err = 1'b0;
`endif

    assign bus.cmd_ready                  = ~fifo_full;
    assign bus.burst_consumed_valid       = consume_valid_reg;
    assign bus.burst_counsumed_burstcount = consume_count_reg;
    assign bus.err_zero_size              = err_zero_reg;
    assign bus.sched_busy                 = (state_reg == ST_WAIT_DATA) | consume_valid_reg;

endmodule

// File: tb/tb_alt_mem_ddrx_burst_consume_sched.sv
// Self-checking bench for alt_mem_ddrx_burst_consume_sched.
// The reference model is a queue of command sizes plus a one-cycle-registered
// tracker: a command pops when its size fits in pending minus the pulse
// currently on the wire, size-0 commands are dropped with an error pulse.
module tb_alt_mem_ddrx_burst_consume_sched;

    localparam int TRACK_W  = 7;
    localparam int SIZE_W   = 4;
    localparam int DEPTH    = 8;
    localparam int STALL_TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alt_mem_ddrx_burst_consume_sched_if #(
        .TRACK_W (TRACK_W),
        .SIZE_W  (SIZE_W)
    ) bus ();

    alt_mem_ddrx_burst_consume_sched #(
        .CFG_BURSTCOUNT_TRACKING_WIDTH (TRACK_W),
        .CFG_INT_SIZE_WIDTH            (SIZE_W),
        .CFG_CMD_FIFO_DEPTH            (DEPTH)
`ifdef ALT_MEM_DDRX_BURST_SCHED_STALL_TIMEOUT_EN
        ,
        .CFG_STALL_TIMEOUT             (STALL_TO)
`endif
    ) dut (
        .ctl_clk   (clk),
        .ctl_reset (rst),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    int q[$];
    int pending   = 0;
    bit exp_valid = 0;
    int exp_cnt   = 0;
    bit exp_err   = 0;
    int run       = 0;
    bit stall_seen = 0;
    int exp_sum   = 0;

    function automatic bit exp_stall();
`ifdef ALT_MEM_DDRX_BURST_SCHED_STALL_TIMEOUT_EN
        return stall_seen;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_size  = '0;
        bus.burst_pending_burstcount = TRACK_W'(pending);
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        exp_valid = 0; exp_cnt = 0; exp_err = 0;
        run = 0; stall_seen = 0;
    endtask

    // One clock of stimulus; the model advances alongside and the DUT is
    // compared against it 1 time unit after the edge.
    task automatic step(input bit v, input int sz, input int add);
        int h; int avail; bit do_pop; bit cons; bit was_full;
        h = 0; avail = 0; do_pop = 0; cons = 0;
        was_full = (q.size() >= DEPTH);
        bus.cmd_valid = v;
        bus.cmd_size  = SIZE_W'(sz);
        bus.burst_pending_burstcount = TRACK_W'(pending);
        if (q.size() > 0) begin
            h = q[0];
            avail = pending - (exp_valid ? exp_cnt : 0);
            if (h == 0) begin
                do_pop = 1;
            end else if (avail >= h) begin
                do_pop = 1;
                cons = 1;
            end
        end
        if (q.size() > 0 && !do_pop) run++; else run = 0;
        if (run >= STALL_TO) stall_seen = 1;
        pending = pending + add - (exp_valid ? exp_cnt : 0);
        @(posedge clk); #1;
        if (do_pop) void'(q.pop_front());
        if (v && !was_full) q.push_back(sz);
        exp_valid = cons;
        exp_cnt   = cons ? h : 0;
        exp_err   = do_pop && (h == 0);
        if (cons) begin
            exp_sum += h;
            $display("consume size=%0d t=%0t", h, $time);
        end
        if (exp_err) $display("zero-size discard t=%0t", $time);
        bus.burst_pending_burstcount = TRACK_W'(pending);

        total++;
        if (bus.cmd_ready !== (q.size() < DEPTH)) begin
            bad++; $display("FAIL cmd_ready: got %0b want %0b t=%0t", bus.cmd_ready, (q.size() < DEPTH), $time);
        end
        total++;
        if (bus.burst_consumed_valid !== exp_valid) begin
            bad++; $display("FAIL consume_valid: got %0b want %0b t=%0t", bus.burst_consumed_valid, exp_valid, $time);
        end
        total++;
        if (bus.burst_counsumed_burstcount !== SIZE_W'(exp_cnt)) begin
            bad++; $display("FAIL consume_count: got %0d want %0d t=%0t", bus.burst_counsumed_burstcount, exp_cnt, $time);
        end
        total++;
        if (bus.err_zero_size !== exp_err) begin
            bad++; $display("FAIL err_zero_size: got %0b want %0b t=%0t", bus.err_zero_size, exp_err, $time);
        end
        total++;
        if (bus.sched_busy !== ((q.size() > 0) || exp_valid)) begin
            bad++; $display("FAIL sched_busy: got %0b want %0b t=%0t", bus.sched_busy, ((q.size() > 0) || exp_valid), $time);
        end
        total++;
        if (bus.stall_err !== exp_stall()) begin
            bad++; $display("FAIL stall_err: got %0b want %0b t=%0t", bus.stall_err, exp_stall(), $time);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready: got %0b want 1", bus.cmd_ready);
        end
        total++;
        if ({bus.burst_consumed_valid, bus.burst_counsumed_burstcount, bus.sched_busy,
             bus.err_zero_size, bus.stall_err} !== '0) begin
            bad++; $display("FAIL reset_outputs: got valid=%0b cnt=%0d busy=%0b err=%0b stall=%0b want all 0",
                bus.burst_consumed_valid, bus.burst_counsumed_burstcount, bus.sched_busy,
                bus.err_zero_size, bus.stall_err);
        end
    endtask

    task automatic test_ramp();
        int first_k; int n_obs;
        do_reset();
        pending = 0;
        first_k = -1; n_obs = 0;
        step(1, 4, 0);
        for (int k = 0; k < 8; k++) begin
            step(0, 0, (k < 4) ? 1 : 0);
            if (bus.burst_consumed_valid === 1'b1) begin
                n_obs++;
                if (first_k < 0) first_k = k;
            end
        end
        total++;
        if (first_k !== 4) begin
            bad++; $display("FAIL ramp_timing: got step %0d want step 4", first_k);
        end
        total++;
        if (n_obs !== 1) begin
            bad++; $display("FAIL ramp_count: got %0d pulses want 1", n_obs);
        end
    endtask

    task automatic test_back_to_back();
        int n_obs; int sum_obs; int first_k; int last_k;
        int sizes[4];
        sizes = '{3, 3, 3, 2};
        do_reset();
        pending = 10;
        n_obs = 0; sum_obs = 0; first_k = -1; last_k = -1;
        for (int k = 0; k < 10; k++) begin
            step(k < 4, (k < 4) ? sizes[k] : 0, 0);
            if (bus.burst_consumed_valid === 1'b1) begin
                n_obs++;
                sum_obs += int'(bus.burst_counsumed_burstcount);
                if (first_k < 0) first_k = k;
                last_k = k;
            end
        end
        total++;
        if (n_obs !== 3 || sum_obs !== 9) begin
            bad++; $display("FAIL b2b_count: got %0d pulses sum %0d want 3 pulses sum 9", n_obs, sum_obs);
        end
        total++;
        if (first_k !== 1 || last_k !== 3) begin
            bad++; $display("FAIL b2b_consecutive: got steps %0d..%0d want 1..3", first_k, last_k);
        end
        total++;
        if (bus.sched_busy !== 1'b1) begin
            bad++; $display("FAIL b2b_size2_waits: got busy %0b want 1", bus.sched_busy);
        end
    endtask

    task automatic test_full();
        int n_obs;
        do_reset();
        pending = 0;
        n_obs = 0;
        for (int k = 0; k < DEPTH; k++) step(1, 1, 0);
        total++;
        if (bus.cmd_ready !== 1'b0) begin
            bad++; $display("FAIL full_ready: got %0b want 0", bus.cmd_ready);
        end
        step(1, 1, 0);          // 9th push, must be held off
        step(1, 1, 1);          // pending becomes 1 at this edge
        step(1, 5, 0);          // pop of a size-1 head; push still refused
        total++;
        if (bus.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL full_pop_ready: got %0b want 1", bus.cmd_ready);
        end
        if (bus.burst_consumed_valid === 1'b1) n_obs++;
        pending = 100;
        for (int k = 0; k < 14; k++) begin
            step(0, 0, 0);
            if (bus.burst_consumed_valid === 1'b1) n_obs++;
        end
        total++;
        if (n_obs !== DEPTH) begin
            bad++; $display("FAIL full_drain: got %0d consumes want %0d", n_obs, DEPTH);
        end
    endtask

    task automatic test_zero_size();
        int n_err; int n_obs; int sum_obs;
        int sizes[3];
        sizes = '{2, 0, 2};
        do_reset();
        pending = 4;
        n_err = 0; n_obs = 0; sum_obs = 0;
        for (int k = 0; k < 9; k++) begin
            step(k < 3, (k < 3) ? sizes[k] : 0, 0);
            if (bus.err_zero_size === 1'b1) n_err++;
            if (bus.burst_consumed_valid === 1'b1) begin
                n_obs++;
                sum_obs += int'(bus.burst_counsumed_burstcount);
            end
        end
        total++;
        if (n_err !== 1) begin
            bad++; $display("FAIL zero_err_pulses: got %0d want 1", n_err);
        end
        total++;
        if (n_obs !== 2 || sum_obs !== 4) begin
            bad++; $display("FAIL zero_consumes: got %0d pulses sum %0d want 2 pulses sum 4", n_obs, sum_obs);
        end
    endtask

    task automatic test_reset_mid();
        int n_obs;
        do_reset();
        pending = 0;
        n_obs = 0;
        step(1, 5, 0);
        step(1, 6, 0);
        step(1, 7, 0);
        do_reset();
        total++;
        if (bus.cmd_ready !== 1'b1 || bus.sched_busy !== 1'b0 ||
            bus.burst_consumed_valid !== 1'b0 || bus.err_zero_size !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs: got ready=%0b busy=%0b valid=%0b err=%0b want 1 0 0 0",
                bus.cmd_ready, bus.sched_busy, bus.burst_consumed_valid, bus.err_zero_size);
        end
        pending = 50;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0);
            if (bus.burst_consumed_valid === 1'b1) n_obs++;
        end
        total++;
        if (n_obs !== 0) begin
            bad++; $display("FAIL midreset_stray: got %0d consumes want 0", n_obs);
        end
    endtask

    task automatic test_stall();
        int n_obs;
        do_reset();
        pending = 2;
        n_obs = 0;
        step(1, 5, 0);
        for (int k = 0; k < 10; k++) step(0, 0, 0);
        total++;
        if (bus.stall_err !== 1'b0) begin
            bad++; $display("FAIL stall_early: got %0b want 0", bus.stall_err);
        end
        for (int k = 0; k < 10; k++) step(0, 0, 0);
        total++;
        if (bus.stall_err !== exp_stall()) begin
            bad++; $display("FAIL stall_set: got %0b want %0b", bus.stall_err, exp_stall());
        end
        step(0, 0, 3);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0);
            if (bus.burst_consumed_valid === 1'b1) n_obs++;
        end
        total++;
        if (n_obs !== 1 || bus.stall_err !== exp_stall()) begin
            bad++; $display("FAIL stall_sticky: got consumes=%0d stall=%0b want 1 and %0b", n_obs, bus.stall_err, exp_stall());
        end
    endtask

    task automatic test_random();
        int sum_obs;
        do_reset();
        pending = 0;
        exp_sum = 0;
        sum_obs = 0;
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 (pending < 100) ? int'($urandom_range(0, 3)) : 0);
            if (bus.burst_consumed_valid === 1'b1) sum_obs += int'(bus.burst_counsumed_burstcount);
        end
        for (int k = 0; k < 60; k++) begin
            step(0, 0, (pending < 100) ? 3 : 0);
            if (bus.burst_consumed_valid === 1'b1) sum_obs += int'(bus.burst_counsumed_burstcount);
        end
        total++;
        if (sum_obs !== exp_sum) begin
            bad++; $display("FAIL random_sum: got %0d want %0d", sum_obs, exp_sum);
        end
        total++;
        if (bus.sched_busy !== 1'b0) begin
            bad++; $display("FAIL random_drained: got busy %0b want 0", bus.sched_busy);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_size  = '0;
        bus.burst_pending_burstcount = '0;
        test_reset();
        test_ramp();
        test_back_to_back();
        test_full();
        test_zero_size();
        test_reset_mid();
        test_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
